// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int WORD_W             = 32;
    localparam int DEFAULT_NLINES     = 4;
    localparam int DEFAULT_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2
    } state_t;

    // Tag width left over once byte, word-offset and index bits are removed
    function automatic int tag_width(input int nlines, input int line_words);
        return 32 - $clog2(nlines) - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid, dirty and data storage: combinational read, synchronous writes.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NLINES     = DEFAULT_NLINES,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter int IDX        = $clog2(NLINES),
    parameter int OFF        = $clog2(LINE_WORDS),
    parameter int TAG        = tag_width(NLINES, LINE_WORDS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [IDX-1:0]                 index,
    output logic [TAG-1:0]                 line_tag,
    output logic                           line_valid,
    output logic                           line_dirty,
    output logic [LINE_WORDS*WORD_W-1:0]   line_data,
    input  logic                           word_we,
    input  logic [OFF-1:0]                 word_off,
    input  logic [WORD_W-1:0]              word_data,
    input  logic                           line_we,
    input  logic [TAG-1:0]                 fill_tag,
    input  logic [LINE_WORDS*WORD_W-1:0]   fill_data,
    input  logic                           clear_dirty
);

    logic [TAG-1:0]               tags  [NLINES];
    logic [LINE_WORDS*WORD_W-1:0] data  [NLINES];
    logic [NLINES-1:0]            valid;
    logic [NLINES-1:0]            dirty;

    assign line_tag   = tags[index];
    assign line_data  = data[index];
    assign line_valid = valid[index];
    assign line_dirty = dirty[index];

    // Storage update; reset wins over a refill landing on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
            for (int i = 0; i < NLINES; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else if (line_we) begin
            data[index]  <= fill_data;
            tags[index]  <= fill_tag;
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else begin
            if (clear_dirty) begin
                dirty[index] <= 1'b0;
            end
            if (word_we) begin
                data[index][int'(word_off)*WORD_W +: WORD_W] <= word_data;
                dirty[index] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back data cache: FSM, hit logic and memory-side muxing.
module dcache
    import dcache_pkg::*;
#(
    parameter int NLINES     = DEFAULT_NLINES,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    addr,
    input  logic [31:0]                    wdata,
    input  logic                           we,
    input  logic                           re,
    output logic [31:0]                    rdata,
    output logic                           dhit,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [31:0]                    mem_addr,
    output logic [32*LINE_WORDS-1:0]       mem_wdata,
    input  logic [32*LINE_WORDS-1:0]       mem_rdata,
    input  logic                           mem_ready
);

    localparam int OFF = $clog2(LINE_WORDS);
    localparam int IDX = $clog2(NLINES);
    localparam int TAG = tag_width(NLINES, LINE_WORDS);

    state_t state, next_state;

    logic [OFF-1:0]               word_off;
    logic [IDX-1:0]               index;
    logic [TAG-1:0]               addr_tag;
    logic [TAG-1:0]               line_tag;
    logic                         line_valid, line_dirty;
    logic [LINE_WORDS*WORD_W-1:0] line_data;
    logic                         hit, access;
    logic                         word_we, line_we, clear_dirty;
    logic                         unused_byte_bits;

    assign word_off         = addr[2 +: OFF];
    assign index            = addr[OFF+2 +: IDX];
    assign addr_tag         = addr[31 -: TAG];
    assign unused_byte_bits = &{1'b0, addr[1:0]};

    assign hit       = line_valid && (line_tag == addr_tag);
    assign access    = re || we;
    assign rdata     = line_data[int'(word_off)*WORD_W +: WORD_W];
    assign mem_wdata = line_data;

    dcache_array #(
        .NLINES(NLINES), .LINE_WORDS(LINE_WORDS), .IDX(IDX), .OFF(OFF), .TAG(TAG)
    ) u_array (
        .clk(clk),
        .reset(reset),
        .index(index),
        .line_tag(line_tag),
        .line_valid(line_valid),
        .line_dirty(line_dirty),
        .line_data(line_data),
        .word_we(word_we),
        .word_off(word_off),
        .word_data(wdata),
        .line_we(line_we),
        .fill_tag(addr_tag),
        .fill_data(mem_rdata),
        .clear_dirty(clear_dirty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state, core handshake and memory request decode
    always_comb begin
        next_state  = state;
        dhit        = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = {addr_tag, index, {(OFF+2){1'b0}}};
        word_we     = 1'b0;
        line_we     = 1'b0;
        clear_dirty = 1'b0;
        case (state)
            IDLE: begin
                dhit    = !access || hit;
                word_we = we && hit;
                if (access && !hit) begin
                    next_state = (line_valid && line_dirty) ? WB : REFILL;
                end
            end
            WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {line_tag, index, {(OFF+2){1'b0}}};
                if (mem_ready) begin
                    clear_dirty = 1'b1;
                    next_state  = REFILL;
                end
            end
            REFILL: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    line_we    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for the direct-mapped data cache.
module tb_dcache;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  addr, wdata, rdata, mem_addr;
    logic         we, re, dhit, mem_req, mem_we, mem_ready;
    logic [127:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    dcache dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .wdata(wdata),
        .we(we),
        .re(re),
        .rdata(rdata),
        .dhit(dhit),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [127:0] line4(input logic [31:0] w3, w2, w1, w0);
        return {w3, w2, w1, w0};
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic w, input logic r, input logic rdy);
        addr      = a;
        wdata     = d;
        we        = w;
        re        = r;
        mem_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence; inputs change 1ns after the rising edge
    initial begin
        reset     = 1'b1;
        mem_rdata = '0;
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_dhit", dhit, 1);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);

        // Cold load of 0x100
        applyStimulus(32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("cold_c0_dhit", dhit, 0);
        checkOutput("cold_c0_req", mem_req, 0);
        mem_rdata = line4(32'd4, 32'd3, 32'd2, 32'd1);
        tick();
        checkOutput("cold_c1_dhit", dhit, 0);
        checkOutput("cold_c1_req", mem_req, 1);
        checkOutput("cold_c1_we", mem_we, 0);
        checkOutput("cold_c1_addr", mem_addr, 32'h100);
        applyStimulus(32'h100, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("cold_c2_dhit", dhit, 1);
        checkOutput("cold_c2_rdata", rdata, 32'd1);
        checkOutput("cold_c2_req", mem_req, 0);
        applyStimulus(32'h10C, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("hit_10c_dhit", dhit, 1);
        checkOutput("hit_10c_rdata", rdata, 32'd4);

        // Store hit to 0x104, then conflicting load of 0x140
        applyStimulus(32'h104, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        checkOutput("st_hit_dhit", dhit, 1);
        tick();
        applyStimulus(32'h104, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("st_hit_readback", rdata, 32'hDEADBEEF);
        applyStimulus(32'h140, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("evict_c0_dhit", dhit, 0);
        tick();
        checkOutput("wb_req", mem_req, 1);
        checkOutput("wb_we", mem_we, 1);
        checkOutput("wb_addr", mem_addr, 32'h100);
        checkOutput("wb_data", mem_wdata, line4(32'd4, 32'd3, 32'hDEADBEEF, 32'd1));
        checkOutput("wb_dhit", dhit, 0);
        applyStimulus(32'h140, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(32'h140, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("rf140_req", mem_req, 1);
        checkOutput("rf140_we", mem_we, 0);
        checkOutput("rf140_addr", mem_addr, 32'h140);
        checkOutput("rf140_dhit", dhit, 0);
        mem_rdata = line4(32'h44, 32'h33, 32'h22, 32'h11);
        applyStimulus(32'h140, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(32'h140, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("ld140_dhit", dhit, 1);
        checkOutput("ld140_rdata", rdata, 32'h11);

        // Store miss to 0x208 over a clean line: refill only, then merge
        applyStimulus(32'h208, 32'h55, 1'b1, 1'b0, 1'b0);
        checkOutput("stm_c0_dhit", dhit, 0);
        tick();
        checkOutput("stm_rf_we", mem_we, 0);
        checkOutput("stm_rf_req", mem_req, 1);
        checkOutput("stm_rf_addr", mem_addr, 32'h200);
        mem_rdata = line4(32'h8003, 32'h8002, 32'h8001, 32'h8000);
        applyStimulus(32'h208, 32'h55, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(32'h208, 32'h55, 1'b1, 1'b0, 1'b0);
        checkOutput("stm_done_dhit", dhit, 1);
        tick();
        applyStimulus(32'h208, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("ld208_dhit", dhit, 1);
        checkOutput("ld208_rdata", rdata, 32'h55);

        // Evict the dirty 0x200 line with a load of 0x300
        applyStimulus(32'h300, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("ev300_c0_dhit", dhit, 0);
        tick();
        checkOutput("wb200_we", mem_we, 1);
        checkOutput("wb200_addr", mem_addr, 32'h200);
        checkOutput("wb200_data", mem_wdata, line4(32'h8003, 32'h55, 32'h8001, 32'h8000));
        applyStimulus(32'h300, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();

        // Memory holds ready low for five refill cycles
        applyStimulus(32'h300, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("wait%0d_req", i), mem_req, 1);
            checkOutput($sformatf("wait%0d_addr", i), mem_addr, 32'h300);
            checkOutput($sformatf("wait%0d_we", i), mem_we, 0);
            checkOutput($sformatf("wait%0d_dhit", i), dhit, 0);
            tick();
        end
        mem_rdata = line4(32'h3, 32'h2, 32'h1, 32'hC0DE);
        applyStimulus(32'h300, 32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("wait6_req", mem_req, 1);
        tick();
        applyStimulus(32'h300, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("wait_done_dhit", dhit, 1);
        checkOutput("wait_done_rdata", rdata, 32'hC0DE);

        // Reset while a refill of 0x380 is outstanding; refill on reset edge dropped
        applyStimulus(32'h380, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("rr_c0_dhit", dhit, 0);
        tick();
        checkOutput("rr_rf_req", mem_req, 1);
        mem_rdata = line4(32'hBAD3, 32'hBAD2, 32'hBAD1, 32'hBAD0);
        reset = 1'b1;
        applyStimulus(32'h380, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        applyStimulus(32'h380, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("rr_after_req", mem_req, 0);
        checkOutput("rr_after_dhit", dhit, 0);
        tick();
        checkOutput("rr_again_req", mem_req, 1);
        checkOutput("rr_again_addr", mem_addr, 32'h380);
        mem_rdata = line4(32'h0, 32'h0, 32'h0, 32'h7777);
        applyStimulus(32'h380, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(32'h380, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("rr_done_dhit", dhit, 1);
        checkOutput("rr_done_rdata", rdata, 32'h7777);

        // Idle with stray mem_ready must change nothing
        mem_rdata = line4(32'hEEEE, 32'hEEEE, 32'hEEEE, 32'hEEEE);
        applyStimulus(32'hABCDEF00, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("idle_dhit", dhit, 1);
        checkOutput("idle_req", mem_req, 0);
        tick();
        applyStimulus(32'hABCDEF00, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle2_req", mem_req, 0);
        applyStimulus(32'h380, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_keep_dhit", dhit, 1);
        checkOutput("idle_keep_rdata", rdata, 32'h7777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
